// File: rtl/bomb_controller.sv
// Bomb controller: arms a countdown, accepts defuse codes with a limited
// number of wrong attempts, supports pausing, and reports the run outcome.
// The counter itself lives outside; this block only drives its controls.
module bomb_controller #(
    parameter logic [3:0] DEFUSE_CODE = 4'b1010,
    parameter logic [1:0] MAX_TRIES   = 2'd3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Arm,
    input  logic       Pause,
    input  logic [3:0] Code_In,
    input  logic       Code_Valid,
    input  logic [3:0] Counter_In,
    input  logic       blow_up_In,
    output logic       Start,
    output logic       Stop,
    output logic       Bomb_Reset,
    output logic [2:0] State_Out,
    output logic [1:0] Tries_Left,
    output logic       Defused,
    output logic       Exploded
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_PAUSED   = 3'd2,
        ST_DEFUSED  = 3'd3,
        ST_EXPLODED = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] tries;
    logic [1:0] tries_next;

    logic code_match;
    logic code_mismatch;
    logic timer_expired;

    // A strobe with any differing bit counts as a wrong attempt.
    assign code_match    = Code_Valid && (Code_In == DEFUSE_CODE);
    assign code_mismatch = Code_Valid && (Code_In != DEFUSE_CODE);

    // Either the counter's own flag or a zero count ends the countdown.
    assign timer_expired = blow_up_In || (Counter_In == 4'd0);

    assign State_Out  = state;
    assign Tries_Left = tries;

    // State and attempt-counter registers; Reset overrides everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            tries <= MAX_TRIES;
        end else begin
            state <= state_next;
            tries <= tries_next;
        end
    end

    // Next-state and attempt bookkeeping in priority order per state.
    always_comb begin
        state_next = state;
        tries_next = tries;
        case (state)
            ST_IDLE: begin
                if (Arm) begin
                    state_next = ST_ARMED;
                    tries_next = MAX_TRIES;
                end
            end
            ST_ARMED: begin
                if (timer_expired) begin
                    state_next = ST_EXPLODED;
                end else if (code_match) begin
                    state_next = ST_DEFUSED;
                end else if (code_mismatch) begin
                    // Saturating decrement; the last allowed miss detonates.
                    tries_next = (tries == 2'd0) ? 2'd0 : (tries - 2'd1);
                    if (tries == 2'd1) begin
                        state_next = ST_EXPLODED;
                    end
                end else if (Pause) begin
                    state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                // Codes are not evaluated while the countdown is held.
                if (blow_up_In) begin
                    state_next = ST_EXPLODED;
                end else if (!Pause) begin
                    state_next = ST_ARMED;
                end
            end
            ST_DEFUSED, ST_EXPLODED: begin
                if (Arm) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                // Unused encodings recover to a safe, reloaded counter.
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state only.
    always_comb begin
        Start      = 1'b0;
        Stop       = 1'b0;
        Bomb_Reset = 1'b0;
        Defused    = 1'b0;
        Exploded   = 1'b0;
        case (state)
            ST_IDLE: begin
                Bomb_Reset = 1'b1;
            end
            ST_ARMED: begin
                Start = 1'b1;
            end
            ST_PAUSED: begin
                Stop = 1'b1;
            end
            ST_DEFUSED: begin
                Stop    = 1'b1;
                Defused = 1'b1;
            end
            ST_EXPLODED: begin
                Stop     = 1'b1;
                Exploded = 1'b1;
            end
            default: begin
                Start = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bomb_controller.sv
// Testbench for bomb_controller: directed scenarios followed by random
// stimulus, all compared each cycle against a behavioural model.
module tb_bomb_controller;

    localparam logic [3:0] DEF_CODE = 4'b1010;
    localparam logic [1:0] MAXT     = 2'd3;

    logic       Clock;
    logic       Reset;
    logic       Arm;
    logic       Pause;
    logic [3:0] Code_In;
    logic       Code_Valid;
    logic [3:0] Counter_In;
    logic       blow_up_In;
    logic       Start;
    logic       Stop;
    logic       Bomb_Reset;
    logic [2:0] State_Out;
    logic [1:0] Tries_Left;
    logic       Defused;
    logic       Exploded;

    int errors = 0;
    int checks = 0;

    bomb_controller #(
        .DEFUSE_CODE (DEF_CODE),
        .MAX_TRIES   (MAXT)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Arm        (Arm),
        .Pause      (Pause),
        .Code_In    (Code_In),
        .Code_Valid (Code_Valid),
        .Counter_In (Counter_In),
        .blow_up_In (blow_up_In),
        .Start      (Start),
        .Stop       (Stop),
        .Bomb_Reset (Bomb_Reset),
        .State_Out  (State_Out),
        .Tries_Left (Tries_Left),
        .Defused    (Defused),
        .Exploded   (Exploded)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model: phase number as the spec encodes it, attempts as an int.
    localparam int P_IDLE = 0, P_ARMED = 1, P_PAUSED = 2, P_DEFUSED = 3, P_EXPLODED = 4;
    int m_phase = P_IDLE;
    int m_tries = 3;
    // {Start, Stop, Bomb_Reset, Defused, Exploded} expected per phase
    logic [4:0] out_tbl [0:4] = '{5'b00100, 5'b10000, 5'b01000, 5'b01010, 5'b01001};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (Reset) begin
            m_phase = P_IDLE;
            m_tries = int'(MAXT);
        end else if (m_phase == P_IDLE) begin
            if (Arm) begin
                m_phase = P_ARMED;
                m_tries = int'(MAXT);
            end
        end else if (m_phase == P_ARMED) begin
            if (blow_up_In || Counter_In == 4'd0) m_phase = P_EXPLODED;
            else if (Code_Valid && Code_In == DEF_CODE) m_phase = P_DEFUSED;
            else if (Code_Valid) begin
                if (m_tries == 1) m_phase = P_EXPLODED;
                if (m_tries > 0) m_tries = m_tries - 1;
            end else if (Pause) m_phase = P_PAUSED;
        end else if (m_phase == P_PAUSED) begin
            if (blow_up_In) m_phase = P_EXPLODED;
            else if (!Pause) m_phase = P_ARMED;
        end else begin
            if (Arm) m_phase = P_IDLE;
        end
    endtask

    // One clock: model advances with the inputs seen at the edge, then compare.
    task automatic tick(input string tag);
        @(posedge Clock);
        model_edge();
        #1;
        check({tag, ".state"}, 32'(State_Out), 32'(m_phase));
        check({tag, ".tries"}, 32'(Tries_Left), 32'(m_tries));
        check({tag, ".outs"}, 32'({Start, Stop, Bomb_Reset, Defused, Exploded}),
              32'(out_tbl[m_phase]));
    endtask

    task automatic idle_inputs();
        Arm = 1'b0; Pause = 1'b0; Code_Valid = 1'b0; Code_In = 4'd0;
        blow_up_In = 1'b0; Counter_In = 4'd9;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();

        // Reset state
        tick("reset");
        check("reset.bomb_reset", 32'(Bomb_Reset), 32'd1);
        check("reset.state_const", 32'(State_Out), 32'd0);
        Reset = 1'b0;
        tick("idle_hold");

        // Arm for one cycle
        Arm = 1'b1;
        tick("arm");
        Arm = 1'b0;
        check("arm.state_const", 32'(State_Out), 32'd1);
        check("arm.start_const", 32'(Start), 32'd1);
        check("arm.tries_const", 32'(Tries_Left), 32'd3);
        tick("armed_quiet");

        // Correct code defuses
        Counter_In = 4'd9; Code_In = DEF_CODE; Code_Valid = 1'b1;
        tick("defuse");
        Code_Valid = 1'b0;
        check("defuse.state_const", 32'(State_Out), 32'd3);
        check("defuse.flags_const", 32'({Defused, Stop, Start}), 32'b110);
        tick("defused_hold");
        Arm = 1'b1; tick("defused_clear");
        tick("rearm");
        Arm = 1'b0;

        // Three wrong codes, last one detonates; a near-miss code included
        Code_In = 4'b0001; Code_Valid = 1'b1; tick("miss1");
        Code_Valid = 1'b0; tick("miss_gap");
        Code_In = 4'b1011; Code_Valid = 1'b1; tick("miss2");
        Code_In = 4'b0001; tick("miss3");
        Code_Valid = 1'b0;
        check("miss3.exploded_const", 32'({Exploded, Tries_Left}), 32'b100);
        Arm = 1'b1; tick("exploded_clear");
        tick("rearm2");
        Arm = 1'b0;

        // Pause for five cycles with an ignored correct strobe
        Pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Code_In = DEF_CODE; Code_Valid = (i == 2);
            tick("paused");
        end
        Code_Valid = 1'b0;
        check("paused.stop_const", 32'({Stop, State_Out}), 32'b1010);
        Pause = 1'b0; tick("unpause");

        // Mismatch beats Pause in the same cycle
        Pause = 1'b1; Code_In = 4'b0000; Code_Valid = 1'b1; tick("miss_vs_pause");
        Code_Valid = 1'b0; Pause = 1'b0; tick("armed_after");

        // Zero count beats a correct code
        Counter_In = 4'd0; Code_In = DEF_CODE; Code_Valid = 1'b1; tick("zero_vs_code");
        Code_Valid = 1'b0; Counter_In = 4'd9;
        check("zero_vs_code.const", 32'(State_Out), 32'd4);
        Arm = 1'b1; tick("clear3"); tick("rearm3"); Arm = 1'b0;

        // blow_up while paused
        Pause = 1'b1; tick("pause2");
        blow_up_In = 1'b1; tick("paused_blow");
        blow_up_In = 1'b0; Pause = 1'b0;
        Arm = 1'b1; tick("clear4"); tick("rearm4"); Arm = 1'b0;

        // Reset mid-countdown with one try left
        Code_In = 4'b0101; Code_Valid = 1'b1; tick("m1"); tick("m2");
        Code_Valid = 1'b0;
        Reset = 1'b1; tick("reset_mid");
        Reset = 1'b0;
        check("reset_mid.const", 32'({Bomb_Reset, Tries_Left, State_Out}), 32'b111000);
        tick("after_reset");

        // Random stimulus
        for (int n = 0; n < 800; n++) begin
            Reset      = ($urandom_range(0, 63) == 0);
            Arm        = ($urandom_range(0, 3) == 0);
            Pause      = ($urandom_range(0, 4) == 0);
            Code_Valid = ($urandom_range(0, 2) == 0);
            Code_In    = ($urandom_range(0, 2) == 0) ? DEF_CODE : 4'($urandom_range(0, 15));
            Counter_In = ($urandom_range(0, 19) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            blow_up_In = ($urandom_range(0, 39) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bomb_controller.md
BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 Parameter DEFUSE_CODE, default 4'b1010: code that defuses an armed countdown.
REQ-002 Parameter MAX_TRIES, default 2'd3: wrong-code attempts allowed per arming; legal range 1..3.
REQ-003 Clock  input  1  sole clock; all state changes on posedge Clock.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Arm  input  1  level request to arm (IDLE) or to clear a finished run (DEFUSED/EXPLODED).
REQ-006 Pause  input  1  level; holds the countdown while high.
REQ-007 Code_In  input  4  candidate defuse code.
REQ-008 Code_Valid  input  1  one-cycle strobe qualifying Code_In.
REQ-009 Counter_In  input  4  current value from the countdown counter.
REQ-010 blow_up_In  input  1  detonation flag from the countdown counter.
REQ-011 Start  output  1  countdown enable to the counter.
REQ-012 Stop  output  1  countdown hold to the counter.
REQ-013 Bomb_Reset  output  1  counter reload (counter reloads to 4'b1111).
REQ-014 State_Out  output  3  encoded FSM state.
REQ-015 Tries_Left  output  2  remaining wrong-code attempts.
REQ-016 Defused  output  1  high while in DEFUSED.
REQ-017 Exploded  output  1  high while in EXPLODED.

Function
REQ-018 The FSM SHALL have states IDLE=3'd0, ARMED=3'd1, PAUSED=3'd2, DEFUSED=3'd3, EXPLODED=3'd4; State_Out SHALL equal the state register; codes 5-7 SHALL return to IDLE on the next edge.
REQ-019 Start, Stop, Bomb_Reset, Defused and Exploded SHALL be decoded from the state register only (Moore), so they change in the cycle after the transition edge:
- IDLE: Bomb_Reset=1, Start=0, Stop=0
- ARMED: Start=1, Stop=0, Bomb_Reset=0
- PAUSED: Stop=1, Start=0, Bomb_Reset=0
- DEFUSED: Stop=1, Defused=1, others 0
- EXPLODED: Stop=1, Exploded=1, others 0
REQ-020 IDLE: Arm=1 SHALL go to ARMED and load Tries_Left=MAX_TRIES; otherwise stay.
REQ-021 ARMED SHALL evaluate, highest priority first:
- (a) blow_up_In=1 or Counter_In==4'd0 -> EXPLODED
- (b) Code_Valid=1 and Code_In==DEFUSE_CODE -> DEFUSED
- (c) Code_Valid=1 and mismatch -> Tries_Left-1; if Tries_Left was 1 -> EXPLODED, else stay ARMED
- (d) Pause=1 -> PAUSED
REQ-022 A mismatch in (c) SHALL take priority over Pause in the same cycle; Arm SHALL be ignored in ARMED.
REQ-023 PAUSED: blow_up_In=1 -> EXPLODED; else Pause=0 -> ARMED; Code_Valid SHALL be ignored and Tries_Left held.
REQ-024 DEFUSED and EXPLODED SHALL hold until Arm=1, which moves to IDLE; a new run requires a further Arm in IDLE.
REQ-025 Tries_Left SHALL saturate at 0, change only on a mismatch in ARMED, and hold in every other state.
REQ-026 Code comparison SHALL be exact on all 4 bits; Code_Valid=0 cycles SHALL have no effect.

Reset
REQ-027 Reset=1 at a clock edge SHALL force IDLE and Tries_Left=MAX_TRIES, overriding every other input in any state, including mid-countdown.
REQ-028 From that edge onward the outputs SHALL read Bomb_Reset=1, Start=0, Stop=0, Defused=0, Exploded=0, State_Out=3'd0.

Verification
REQ-029 Reset, then Arm=1 for one cycle -> State_Out=1, Start=1, Bomb_Reset=0, Tries_Left=3.
REQ-030 ARMED, Counter_In=4'd9, Code_In=4'b1010 with Code_Valid=1 -> State_Out=3, Defused=1, Stop=1, Start=0.
REQ-031 ARMED, three strobes of Code_In=4'b0001 -> Tries_Left 2, 1, 0; EXPLODED after the third; Exploded=1.
REQ-032 ARMED, Pause=1 for 5 cycles including a correct-code strobe -> PAUSED, Stop=1, strobe ignored; Pause=0 -> ARMED, Tries_Left unchanged.
REQ-033 ARMED, Counter_In=4'd0 with correct code strobed in the same cycle -> EXPLODED, not DEFUSED.
REQ-034 ARMED with Tries_Left=1, then Reset=1 for one cycle -> IDLE, Bomb_Reset=1, Tries_Left=3 on the next cycle.
